// File: rtl/divider_seq_if.sv
// divider_seq_if -- handshake and data bundle for the sequential divider.
//
// Purpose: groups the request side (strt, operands, optional is_signed) and
// the result side (quotient, remainder, not_valid, idle, done) of
// divider_seq so that they travel as one port.
//
// Signals:
//   strt       request, driven by master
//   is_signed  operands are two's complement (only with DIVIDER_SIGNED_EN)
//   dividend   numerator, BITSIZE bits, driven by master
//   divisor    denominator, BITSIZE bits, driven by master
//   quotient   registered result, driven by slave
//   remainder  registered result, driven by slave
//   not_valid  last result came from a zero divisor, driven by slave
//   idle       divider ready for strt, driven by slave
//   done       one-cycle pulse marking a new result, driven by slave
//
// Configuration macro: DIVIDER_SIGNED_EN adds the is_signed signal.

interface divider_seq_if #(
  parameter int BITSIZE = 16
);
  logic               strt;
`ifdef DIVIDER_SIGNED_EN
  logic               is_signed;
`endif
  logic [BITSIZE-1:0] dividend;
  logic [BITSIZE-1:0] divisor;
  logic [BITSIZE-1:0] quotient;
  logic [BITSIZE-1:0] remainder;
  logic               not_valid;
  logic               idle;
  logic               done;

`ifdef DIVIDER_SIGNED_EN
  modport master (
    output strt, is_signed, dividend, divisor,
    input  quotient, remainder, not_valid, idle, done
  );

  modport slave (
    input  strt, is_signed, dividend, divisor,
    output quotient, remainder, not_valid, idle, done
  );
`else
  modport master (
    output strt, dividend, divisor,
    input  quotient, remainder, not_valid, idle, done
  );

  modport slave (
    input  strt, dividend, divisor,
    output quotient, remainder, not_valid, idle, done
  );
`endif

endinterface : divider_seq_if

// File: rtl/divider_seq.sv
// divider_seq -- multi-cycle restoring divider.
//
// Purpose: divides dividend by divisor one quotient bit per clock, MSB first,
// on operand magnitudes. A nonzero divisor takes BITSIZE CALC cycles plus one
// POSTCALC cycle; a zero divisor skips CALC and reports quotient = all ones,
// remainder = dividend, not_valid = 1.
//
// Ports:
//   clk   rising-edge clock for all state
//   rst   asynchronous, active-high reset; forces IDLE and clears results
//   bus   divider_seq_if.slave: strt, [is_signed], dividend, divisor in;
//         quotient, remainder, not_valid, idle, done out
//
// Parameters:
//   BITSIZE    operand/result width (4..64)
//   INDEXSIZE  bit-index counter width, ceil(log2(BITSIZE))
//
// Configuration macro: DIVIDER_SIGNED_EN
//   defined   : is_signed honoured; magnitudes taken at acceptance and sign
//               correction applied in POSTCALC (truncation toward zero,
//               remainder follows the dividend's sign).
//   undefined : unsigned only; POSTCALC just registers the results. Latency
//               is the same in both builds.

module divider_seq #(
  parameter int BITSIZE   = 16,
  parameter int INDEXSIZE = 4
) (
  input  logic         clk,
  input  logic         rst,
  divider_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CALC     = 2'd1,
    POSTCALC = 2'd2
  } state_t;

  state_t               state_reg;

  // Operand magnitudes captured at acceptance; dvd_reg stays intact through
  // CALC and is walked with idx_reg rather than shifted.
  logic [BITSIZE-1:0]   dvd_reg;
  logic [BITSIZE-1:0]   dvs_reg;
  logic [INDEXSIZE-1:0] idx_reg;
  logic [BITSIZE-1:0]   acc_reg;      // partial remainder
  logic [BITSIZE-1:0]   quo_reg;      // quotient magnitude being built
  logic                 zero_reg;     // accepted divisor was zero

  logic [BITSIZE-1:0]   quotient_reg;
  logic [BITSIZE-1:0]   remainder_reg;
  logic                 not_valid_reg;
  logic                 done_reg;

`ifdef DIVIDER_SIGNED_EN
  logic                 dvd_neg_reg;
  logic                 dvs_neg_reg;
`endif

  // ---------------------------------------------------------------------
  // Operand conditioning at acceptance
  // ---------------------------------------------------------------------
  logic [BITSIZE-1:0]   dvd_mag;
  logic [BITSIZE-1:0]   dvs_mag;
`ifdef DIVIDER_SIGNED_EN
  logic                 dvd_neg;
  logic                 dvs_neg;
`endif

  always_comb begin
`ifdef DIVIDER_SIGNED_EN
    dvd_neg = bus.is_signed & bus.dividend[BITSIZE-1];
    dvs_neg = bus.is_signed & bus.divisor[BITSIZE-1];
    // The magnitude of MIN is MIN itself, which is correct read as unsigned.
    dvd_mag = dvd_neg ? -bus.dividend : bus.dividend;
    dvs_mag = dvs_neg ? -bus.divisor  : bus.divisor;
`else
    dvd_mag = bus.dividend;
    dvs_mag = bus.divisor;
`endif
  end

  // ---------------------------------------------------------------------
  // One restoring step
  // ---------------------------------------------------------------------
  // The shifted partial remainder needs BITSIZE+1 bits: with a divisor whose
  // MSB is set, acc_reg can exceed 2^(BITSIZE-1) and the shift carries out.
  logic [BITSIZE:0]     partial;
  logic [BITSIZE:0]     trial;
  logic                 fits;
  logic [BITSIZE-1:0]   acc_next;
  logic                 unused_trial_msb;

  always_comb begin
    partial  = {acc_reg, dvd_reg[idx_reg]};
    trial    = partial - {1'b0, dvs_reg};
    fits     = (partial >= {1'b0, dvs_reg});
    // A successful trial leaves a value below the divisor, so its top bit
    // is always zero and the low BITSIZE bits are the whole result.
    acc_next = fits ? trial[BITSIZE-1:0] : partial[BITSIZE-1:0];
  end

  assign unused_trial_msb = trial[BITSIZE];

  // ---------------------------------------------------------------------
  // Final results presented to POSTCALC
  // ---------------------------------------------------------------------
  logic [BITSIZE-1:0]   res_quotient;
  logic [BITSIZE-1:0]   res_remainder;

  always_comb begin
    res_quotient  = quo_reg;
    res_remainder = acc_reg;
`ifdef DIVIDER_SIGNED_EN
    if (zero_reg) begin
      // Reproduce the original dividend bit pattern from its magnitude.
      res_quotient  = '1;
      res_remainder = dvd_neg_reg ? -dvd_reg : dvd_reg;
    end else begin
      // Quotient is negative when operand signs differ; remainder follows
      // the dividend. Negating zero stays zero, so a zero remainder is
      // never negative. MIN/-1 leaves quo_reg = MIN unchanged (wrap).
      res_quotient  = (dvd_neg_reg ^ dvs_neg_reg) ? -quo_reg : quo_reg;
      res_remainder = dvd_neg_reg ? -acc_reg : acc_reg;
    end
`else
    if (zero_reg) begin
      res_quotient  = '1;
      res_remainder = dvd_reg;
    end
`endif
  end

  // ---------------------------------------------------------------------
  // Controller and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      idx_reg       <= '0;
      acc_reg       <= '0;
      quo_reg       <= '0;
      zero_reg      <= 1'b0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      not_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      dvd_neg_reg   <= 1'b0;
      dvs_neg_reg   <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.strt) begin
            dvd_reg  <= dvd_mag;
            dvs_reg  <= dvs_mag;
            idx_reg  <= INDEXSIZE'(BITSIZE - 1);
            acc_reg  <= '0;
            quo_reg  <= '0;
            zero_reg <= (bus.divisor == '0);
`ifdef DIVIDER_SIGNED_EN
            dvd_neg_reg <= dvd_neg;
            dvs_neg_reg <= dvs_neg;
`endif
            state_reg <= (bus.divisor == '0) ? POSTCALC : CALC;
          end
        end

        CALC: begin
          acc_reg          <= acc_next;
          quo_reg[idx_reg] <= fits;
          idx_reg          <= idx_reg - 1'b1;
          if (idx_reg == '0) begin
            state_reg <= POSTCALC;
          end
        end

        POSTCALC: begin
          quotient_reg  <= res_quotient;
          remainder_reg <= res_remainder;
          not_valid_reg <= zero_reg;
          done_reg      <= 1'b1;
          state_reg     <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.quotient  = quotient_reg;
  assign bus.remainder = remainder_reg;
  assign bus.not_valid = not_valid_reg;
  assign bus.done      = done_reg;
  assign bus.idle      = (state_reg == IDLE);

endmodule : divider_seq

// File: tb/tb_divider_seq.sv
// tb_divider_seq -- self-checking bench for divider_seq (BITSIZE = 16).
//
// Purpose: applies a table of directed vectors, hand-written sequences for
// ignored strt, reset during CALC and back-to-back operation, then random
// operations compared with an arithmetic reference model.
// Honours DIVIDER_SIGNED_EN the same way the design does.

module tb_divider_seq;

  localparam int W = 16;

  logic clk;
  logic rst;

  divider_seq_if #(.BITSIZE(W)) bus ();

  divider_seq #(
    .BITSIZE   (W),
    .INDEXSIZE (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    string      name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic       s;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic       nv;
    int         lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_inputs(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    bus.dividend = a;
    bus.divisor  = b;
`ifdef DIVIDER_SIGNED_EN
    bus.is_signed = s;
`else
    if (s) $display("note: signed request ignored in unsigned build");
`endif
  endtask

  // Reference: plain integer arithmetic on the operands as the user sees them.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic nv);
    int sa;
    int sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (b == '0) begin
      q  = '1;
      r  = a;
      nv = 1'b1;
    end else if (s) begin
      if (sa == -32768 && sb == -1) begin
        q = 16'h8000;
        r = '0;
      end else begin
        q = W'(sa / sb);
        r = W'(sa % sb);
      end
      nv = 1'b0;
    end else begin
      q  = a / b;
      r  = a % b;
      nv = 1'b0;
    end
  endfunction

  // Called at posedge+1 with the divider idle. Returns the result and the
  // number of clock edges from the accepting edge to done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic nv, output int lat);
    set_inputs(a, b, s);
    bus.strt = 1'b1;
    @(posedge clk); #1;
    bus.strt = 1'b0;
    // Scramble operands after acceptance; the result must not follow them.
    set_inputs(W'($urandom), W'($urandom), 1'b0);
    check("idle_after_accept", 64'(bus.idle), 64'd0);
    lat = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
      if (lat > 60) begin
        check("done_timeout", 64'(lat), 64'd17);
        break;
      end
    end
    q  = bus.quotient;
    r  = bus.remainder;
    nv = bus.not_valid;
    @(posedge clk); #1;
    check("done_single_cycle", 64'(bus.done), 64'd0);
  endtask

  task automatic add_vec(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] q, input logic [W-1:0] r,
                         input logic nv, input int lat);
    vec_t v;
    v.name = name; v.a = a; v.b = b; v.s = s;
    v.q = q; v.r = r; v.nv = nv; v.lat = lat;
    vecs.push_back(v);
  endtask

  initial begin
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         nv;
    logic         env;
    logic         s;
    logic [W-1:0] a;
    logic [W-1:0] b;
    int           lat;
    int           cyc;
    int           k;
    int           n_done;
    logic         prev_done;
    logic [W-1:0] b2b_a [3];
    logic [W-1:0] b2b_b [3];

    // ---- expected-value table ----
    add_vec("u_100_7",      16'd100,   16'd7,      1'b0, 16'd14,   16'd2,    1'b0, 17);
    add_vec("u_5_0",        16'd5,     16'd0,      1'b0, 16'hFFFF, 16'd5,    1'b1, 1);
    add_vec("u_ffff_1",     16'hFFFF,  16'd1,      1'b0, 16'hFFFF, 16'd0,    1'b0, 17);
    add_vec("u_0_5",        16'd0,     16'd5,      1'b0, 16'd0,    16'd0,    1'b0, 17);
    add_vec("u_ffff_ffff",  16'hFFFF,  16'hFFFF,   1'b0, 16'd1,    16'd0,    1'b0, 17);
    add_vec("u_8000_8001",  16'h8000,  16'h8001,   1'b0, 16'd0,    16'h8000, 1'b0, 17);
    add_vec("u_ffff_8000",  16'hFFFF,  16'h8000,   1'b0, 16'd1,    16'h7FFF, 1'b0, 17);
    add_vec("u_7_9",        16'd7,     16'd9,      1'b0, 16'd0,    16'd7,    1'b0, 17);
    add_vec("u_1234_1",     16'd1234,  16'd1,      1'b0, 16'd1234, 16'd0,    1'b0, 17);
    add_vec("u_0_0",        16'd0,     16'd0,      1'b0, 16'hFFFF, 16'd0,    1'b1, 1);
`ifdef DIVIDER_SIGNED_EN
    add_vec("s_m7_2",       16'hFFF9,  16'd2,      1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 17);
    add_vec("s_min_m1",     16'h8000,  16'hFFFF,   1'b1, 16'h8000, 16'd0,    1'b0, 17);
    add_vec("s_7_m2",       16'd7,     16'hFFFE,   1'b1, 16'hFFFD, 16'd1,    1'b0, 17);
    add_vec("s_m6_3",       16'hFFFA,  16'd3,      1'b1, 16'hFFFE, 16'd0,    1'b0, 17);
    add_vec("s_m7_0",       16'hFFF9,  16'd0,      1'b1, 16'hFFFF, 16'hFFF9, 1'b1, 1);
    add_vec("s_m8_m3",      16'hFFF8,  16'hFFFD,   1'b1, 16'd2,    16'hFFFE, 1'b0, 17);
`endif

    // ---- reset state ----
    rst      = 1'b1;
    bus.strt = 1'b0;
    set_inputs('0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_quotient",  64'(bus.quotient),  64'd0);
    check("rst_remainder", 64'(bus.remainder), 64'd0);
    check("rst_not_valid", 64'(bus.not_valid), 64'd0);
    check("rst_done",      64'(bus.done),      64'd0);
    check("rst_idle",      64'(bus.idle),      64'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // ---- table ----
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].s, q, r, nv, lat);
      $display("txn %s: %0h/%0h s=%0d -> q=%0h r=%0h nv=%0d lat=%0d",
               vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, q, r, nv, lat);
      check({vecs[i].name, "_q"},   64'(q),   64'(vecs[i].q));
      check({vecs[i].name, "_r"},   64'(r),   64'(vecs[i].r));
      check({vecs[i].name, "_nv"},  64'(nv),  64'(vecs[i].nv));
      check({vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].lat));
    end

    // ---- strt mid-CALC is ignored ----
    set_inputs(16'hFFFF, 16'd1, 1'b0);
    bus.strt = 1'b1;
    @(posedge clk); #1;
    bus.strt = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    set_inputs(16'd3, 16'd3, 1'b0);
    bus.strt = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.strt = 1'b0;
    set_inputs(16'd77, 16'd0, 1'b0);
    lat = 6;
    while (!bus.done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("txn midcalc_strt: ffff/1 -> q=%0h r=%0h lat=%0d", bus.quotient, bus.remainder, lat);
    check("midcalc_lat", 64'(lat),           64'd17);
    check("midcalc_q",   64'(bus.quotient),  64'hFFFF);
    check("midcalc_r",   64'(bus.remainder), 64'd0);
    @(posedge clk); #1;
    check("midcalc_idle", 64'(bus.idle), 64'd1);

    // ---- asynchronous reset five cycles into CALC ----
    set_inputs(16'd100, 16'd7, 1'b0);
    bus.strt = 1'b1;
    @(posedge clk); #1;
    bus.strt = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("abort_busy", 64'(bus.idle), 64'd0);
    #3;
    rst = 1'b1;
    #1;
    check("abort_quotient",  64'(bus.quotient),  64'd0);
    check("abort_remainder", 64'(bus.remainder), 64'd0);
    check("abort_not_valid", 64'(bus.not_valid), 64'd0);
    check("abort_done",      64'(bus.done),      64'd0);
    check("abort_idle",      64'(bus.idle),      64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    n_done = 0;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
    $display("txn abort: done pulses after reset=%0d", n_done);
    check("abort_no_done", 64'(n_done),  64'd0);
    check("abort_idle_after", 64'(bus.idle), 64'd1);
    run_op(16'd9, 16'd3, 1'b0, q, r, nv, lat);
    $display("txn after_abort 9/3: q=%0h r=%0h lat=%0d", q, r, lat);
    check("after_abort_q",   64'(q),   64'd3);
    check("after_abort_r",   64'(r),   64'd0);
    check("after_abort_lat", 64'(lat), 64'd17);

    // ---- strt held high: back-to-back operations ----
    b2b_a[0] = 16'd100;   b2b_b[0] = 16'd7;
    b2b_a[1] = 16'd40000; b2b_b[1] = 16'd123;
    b2b_a[2] = 16'h8000;  b2b_b[2] = 16'h8000;
    set_inputs(b2b_a[0], b2b_b[0], 1'b0);
    bus.strt  = 1'b1;
    k         = 0;
    cyc       = 0;
    prev_done = 1'b0;
    while (k < 3 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      if (prev_done) check("b2b_done_width", 64'(bus.done), 64'd0);
      prev_done = bus.done;
      if (bus.done) begin
        model(b2b_a[k], b2b_b[k], 1'b0, eq, er, env);
        $display("txn b2b%0d: %0h/%0h -> q=%0h r=%0h cycle=%0d",
                 k, b2b_a[k], b2b_b[k], bus.quotient, bus.remainder, cyc);
        check("b2b_q",     64'(bus.quotient),  64'(eq));
        check("b2b_r",     64'(bus.remainder), 64'(er));
        check("b2b_cycle", 64'(cyc),           64'(18 * (k + 1)));
        k++;
        if (k < 3) set_inputs(b2b_a[k], b2b_b[k], 1'b0);
        else       bus.strt = 1'b0;
      end
    end
    check("b2b_count", 64'(k), 64'd3);
    @(posedge clk); #1;
    check("b2b_stop_done", 64'(bus.done), 64'd0);
    check("b2b_stop_idle", 64'(bus.idle), 64'd1);

    // ---- random operations against the model ----
    for (int n = 0; n < 150; n++) begin
      a = W'($urandom);
      case ($urandom_range(0, 7))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = W'($urandom) | 16'h8000;
        default: b = W'($urandom);
      endcase
`ifdef DIVIDER_SIGNED_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      model(a, b, s, eq, er, env);
      run_op(a, b, s, q, r, nv, lat);
      $display("txn rnd%0d: %0h/%0h s=%0d -> q=%0h r=%0h nv=%0d lat=%0d",
               n, a, b, s, q, r, nv, lat);
      check("rnd_q",   64'(q),   64'(eq));
      check("rnd_r",   64'(r),   64'(er));
      check("rnd_nv",  64'(nv),  64'(env));
      check("rnd_lat", 64'(lat), (b == '0) ? 64'd1 : 64'd17);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_divider_seq

// File: doc/divider_seq.md
DIVIDER_SEQ -- requirements
Module: divider_seq

Interface
REQ-001 The block SHALL have parameter BITSIZE, default 16, giving the operand and result width (legal range 4..64).
REQ-002 The block SHALL have parameter INDEXSIZE, default 4, giving the bit-index counter width, equal to ceil(log2(BITSIZE)).
REQ-003 Port clk  input  1  rising-edge clock for all state.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port strt  input  1  start request, sampled only in IDLE.
REQ-006 Port is_signed  input  1  operands are two's complement; present only when DIVIDER_SIGNED_EN is defined.
REQ-007 Port dividend  input  BITSIZE  numerator.
REQ-008 Port divisor  input  BITSIZE  denominator.
REQ-009 Port quotient  output  BITSIZE  registered result.
REQ-010 Port remainder  output  BITSIZE  registered result.
REQ-011 Port not_valid  output  1  registered; last result came from a zero divisor.
REQ-012 Port idle  output  1  high in IDLE; ready to accept strt.
REQ-013 Port done  output  1  one-cycle pulse marking new quotient, remainder and not_valid.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, CALC and POSTCALC.
REQ-015 In IDLE with strt=1 at a clock edge, the block SHALL latch dividend, divisor and is_signed, then go to POSTCALC if divisor==0, else to CALC.
REQ-016 In IDLE with strt=0, the FSM SHALL stay in IDLE and all outputs SHALL hold their values.
REQ-017 CALC SHALL perform restoring division, one quotient bit per cycle from MSB to LSB, on operand magnitudes.
REQ-018 CALC SHALL last exactly BITSIZE cycles, with the index counter wrapping from BITSIZE-1 down to 0, then go to POSTCALC.
REQ-019 Each CALC step SHALL trial-subtract with BITSIZE+1-bit width, so that no carry is lost at divisor MSB=1.
REQ-020 POSTCALC SHALL last one cycle, apply sign correction, write quotient, remainder and not_valid at its exit edge, pulse done=1 for one cycle and return to IDLE.
REQ-021 Latency from the accepting edge to done high SHALL be BITSIZE+1 cycles for a nonzero divisor and 1 cycle for a zero divisor.
REQ-022 A zero divisor SHALL produce quotient = all ones, remainder = dividend and not_valid=1; any other divisor SHALL give not_valid=0.
REQ-023 Results SHALL satisfy dividend = divisor*quotient + remainder, with unsigned remainder < divisor.
REQ-024 Signed results SHALL truncate toward zero, with the remainder taking the dividend's sign and a zero remainder being non-negative.
REQ-025 Signed MIN/-1 SHALL give quotient = MIN (wrap) and remainder = 0, with no flag.
REQ-026 strt SHALL be ignored outside IDLE, and input changes after acceptance SHALL not affect the result.
REQ-027 idle SHALL be combinational from state and SHALL deassert in the cycle after acceptance.
REQ-028 strt in the cycle that done is high SHALL be accepted, giving back-to-back operations.

Reset
REQ-029 rst=1 SHALL force IDLE and clear quotient, remainder, not_valid and done immediately, independent of clk, including mid-CALC.
REQ-030 After rst is released, idle SHALL read 1 and no done SHALL appear for any aborted operation.
REQ-031 The internal dividend, divisor and index registers SHALL be reset to zero.

Configuration
REQ-032 Macro DIVIDER_SIGNED_EN defined SHALL include the is_signed port, magnitude conversion at acceptance and sign correction in POSTCALC.
REQ-033 Macro DIVIDER_SIGNED_EN undefined SHALL remove the is_signed port, make the block unsigned only, leave POSTCALC to only register results, and keep latency identical.

Verification (BITSIZE=16)
REQ-034 The bench SHALL drive 100/7 unsigned -> quotient=14, remainder=2, not_valid=0, done 17 cycles after strt.
REQ-035 The bench SHALL drive 5/0 -> quotient=0xFFFF, remainder=5, not_valid=1, done 1 cycle after strt.
REQ-036 With DIVIDER_SIGNED_EN, the bench SHALL drive -7/2 signed -> quotient=0xFFFD, remainder=0xFFFF; and 0x8000/0xFFFF signed -> quotient=0x8000, remainder=0.
REQ-037 The bench SHALL pulse strt again mid-CALC of 0xFFFF/1 and change the inputs -> the second strt is ignored and the result is quotient=0xFFFF, remainder=0.
REQ-038 The bench SHALL assert rst 5 cycles into CALC -> the outputs clear at once, idle=1, no done; a fresh 9/3 afterwards gives quotient=3, remainder=0.
REQ-039 The bench SHALL hold strt high through done -> back-to-back results, each with a single-cycle done pulse.
